// File: rtl/ps2_mouse_track_funcmod_pkg.sv
// rtl/ps2_mouse_track_funcmod_pkg.sv - shared packet field indices and widths for the mouse tracker
// Purpose: bit positions inside the 32-bit PS/2 packet word, plus the position and wheel widths.
// Ports: none (package).
package ps2_mouse_pkg;

  localparam int PKT_W   = 32;

  // packet bit-field indices
  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int X_SIGN  = 4;
  localparam int Y_SIGN  = 5;
  localparam int X_OVF   = 6;
  localparam int Y_OVF   = 7;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 16;
  localparam int Z_LSB   = 24;

  localparam int POS_W   = 10;
  localparam int WHEEL_W = 8;
  localparam int DELTA_W = 9;
  localparam int CALC_W  = 12;

endpackage

// File: rtl/ps2_mouse_track_funcmod_if.sv
// rtl/ps2_mouse_track_funcmod_if.sv - packet strobe bundle from the PS/2 read stage
// Purpose: carries the packet trigger, packet word and recenter strobe.
// Ports: iTrig (packet strobe), iData (packet word), iClear (recenter strobe).
//   master: read stage / controller side (drives); slave: tracker side (receives).
interface ps2_mouse_track_funcmod_if;
  import ps2_mouse_pkg::*;

  logic             iTrig;
  logic [PKT_W-1:0] iData;
  logic             iClear;

  modport master (output iTrig, output iData, output iClear);
  modport slave  (input  iTrig, input  iData, input  iClear);

endinterface

// File: rtl/ps2_mouse_track_funcmod_clamp_add.sv
// rtl/ps2_mouse_track_funcmod_clamp_add.sv - signed add of a position and a 9-bit delta, clamped to [0, MAX]
// Purpose: one axis of cursor update. NEGATE subtracts the delta instead of adding it.
// Ports: base (12-bit signed position), delta (9-bit signed), result (clamped position).
module clamp_add
  import ps2_mouse_pkg::*;
#(
  parameter int   MAX    = 639,
  parameter logic NEGATE = 1'b0
) (
  input  logic signed [CALC_W-1:0]  base,
  input  logic signed [DELTA_W-1:0] delta,
  output logic        [POS_W-1:0]   result
);

  localparam logic signed [CALC_W-1:0] MAX_S = CALC_W'(MAX);

  logic signed [CALC_W-1:0] delta_ext;
  logic signed [CALC_W-1:0] sum;

  // Negation is done after widening so that -(-256) = +256 is representable.
  always_comb begin
    delta_ext = {{(CALC_W-DELTA_W){delta[DELTA_W-1]}}, delta};
    if (NEGATE) begin
      delta_ext = -delta_ext;
    end
    sum = base + delta_ext;
    if (sum < 0) begin
      result = '0;
    end else if (sum > MAX_S) begin
      result = MAX_S[POS_W-1:0];
    end else begin
      result = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_track_funcmod.sv
// rtl/ps2_mouse_track_funcmod.sv - PS/2 packet decoder accumulating cursor, wheel and button edges
// Purpose: two-stage pipeline. Stage 1 captures the packet deltas/buttons; stage 2 updates the
//   clamped cursor, saturating wheel and button press/release pulses.
// Ports: CLOCK, RESET (sync, active-high); pkt (iTrig/iData/iClear, slave);
//   oX/oY cursor, oZ wheel, oBtn levels {M,R,L}, oPress/oRelease edge pulses, oDone update pulse.
module ps2_mouse_track_funcmod
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  ps2_mouse_track_funcmod_if.slave  pkt,
  output logic [POS_W-1:0]          oX,
  output logic [POS_W-1:0]          oY,
  output logic signed [WHEEL_W-1:0] oZ,
  output logic [2:0]                oBtn,
  output logic [2:0]                oPress,
  output logic [2:0]                oRelease,
  output logic                      oDone
);

  // ---------------- stage 1: decode and register ----------------
  logic                      v1;
  logic                      v2;
  logic signed [DELTA_W-1:0] dx_in, dy_in, dz_in;
  logic signed [DELTA_W-1:0] dx_q, dy_q, dz_q;
  logic [2:0]                btn_in, btn_q;
  logic                      unused_bits;

  always_comb begin
    dx_in  = pkt.iData[X_OVF] ? '0 : {pkt.iData[X_SIGN], pkt.iData[X_LSB +: 8]};
    dy_in  = pkt.iData[Y_OVF] ? '0 : {pkt.iData[Y_SIGN], pkt.iData[Y_LSB +: 8]};
    dz_in  = {{(DELTA_W-4){pkt.iData[Z_LSB+3]}}, pkt.iData[Z_LSB +: 4]};
    btn_in = {pkt.iData[BTN_M], pkt.iData[BTN_R], pkt.iData[BTN_L]};
  end

  assign unused_bits = ^{pkt.iData[PKT_W-1:Z_LSB+4], pkt.iData[3]};

  // A clear in the same cycle as a trigger discards that packet.
  always_ff @(posedge CLOCK) begin
    if (RESET || pkt.iClear) begin
      v1 <= 1'b0;
    end else begin
      v1 <= pkt.iTrig;
      if (pkt.iTrig) begin
        dx_q  <= dx_in;
        dy_q  <= dy_in;
        dz_q  <= dz_in;
        btn_q <= btn_in;
      end
    end
  end

  // ---------------- stage 2: accumulate ----------------
  logic [POS_W-1:0]          nx, ny;
  logic signed [DELTA_W-1:0] nz;
  logic signed [WHEEL_W-1:0] z_sat;

  clamp_add #(.MAX(X_MAX), .NEGATE(1'b0)) u_clamp_x (
    .base   ({2'b00, oX}),
    .delta  (dx_q),
    .result (nx)
  );

  // PS/2 Y grows upward while screen Y grows downward.
  clamp_add #(.MAX(Y_MAX), .NEGATE(1'b1)) u_clamp_y (
    .base   ({2'b00, oY}),
    .delta  (dy_q),
    .result (ny)
  );

  always_comb begin
    nz = $signed({oZ[WHEEL_W-1], oZ}) + dz_q;
    if (nz > 9'sd127) begin
      z_sat = 8'sd127;
    end else if (nz < -9'sd128) begin
      z_sat = -8'sd128;
    end else begin
      z_sat = nz[WHEEL_W-1:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      oX       <= POS_W'(X_INIT);
      oY       <= POS_W'(Y_INIT);
      oZ       <= '0;
      oBtn     <= '0;
      oPress   <= '0;
      oRelease <= '0;
      v2       <= 1'b0;
    end else begin
      oPress   <= '0;
      oRelease <= '0;
      v2       <= 1'b0;
      if (pkt.iClear) begin
        // buttons keep their level so no spurious edges appear afterwards
        oX <= POS_W'(X_INIT);
        oY <= POS_W'(Y_INIT);
        oZ <= '0;
      end else if (v1) begin
        oX       <= nx;
        oY       <= ny;
        oZ       <= z_sat;
        oPress   <= btn_q & ~oBtn;
        oRelease <= ~btn_q & oBtn;
        oBtn     <= btn_q;
        v2       <= 1'b1;
      end
    end
  end

  assign oDone = v2;

endmodule
